mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus bundle of the memory arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_we;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*BLOCK_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ-1:0]         resp_ready;
    logic [BLOCK_W-1:0]         resp_rdata;

    logic                       req_valid_mem;
    logic                       req_ready_mem;
    logic                       read_en_mem;
    logic                       write_en_mem;
    logic [ADDR_W-1:0]          addr_mem;
    logic [BLOCK_W-1:0]         wdata_mem;
    logic                       resp_valid_mem;
    logic                       resp_ready_mem;
    logic [BLOCK_W-1:0]         rdata_mem;

    logic                       grant_id;
    logic                       busy;

    // Arbiter view.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
               req_ready_mem, resp_valid_mem, rdata_mem,
        output req_ready, resp_valid, resp_rdata, req_valid_mem,
               read_en_mem, write_en_mem, addr_mem, wdata_mem,
               resp_ready_mem, grant_id, busy
    );

    // Environment view (requesters plus memory).
    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
               req_ready_mem, resp_valid_mem, rdata_mem,
        input  req_ready, resp_valid, resp_rdata, req_valid_mem,
               read_en_mem, write_en_mem, addr_mem, wdata_mem,
               resp_ready_mem, grant_id, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select with the last-grant pointer.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    input  logic               i_update_id,
    output logic               o_any_c,
    output logic               o_win_c
);
    logic r_last;

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_update_id;
        end
    end

    // Tie goes to the requester not served last; a lone requester always wins.
    always_comb begin
        o_any_c = |i_req;
        o_win_c = 1'b0;
        if (&i_req) begin
            o_win_c = ~r_last;
        end else begin
            o_win_c = i_req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto one memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
)(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    arb_state_t         r_state;
    arb_state_t         w_state;
    arb_state_t         w_state_nxt;
    logic               r_gid;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [BLOCK_W-1:0] r_wdata;

    logic               w_any;
    logic               w_win;
    logic               w_latch;
    logic               w_update;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [BLOCK_W-1:0] w_sel_wdata;

    // Holding reset forces idle behaviour so a stale transaction drives nothing.
    assign w_state = rst ? r_state : ARB_IDLE;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_req       (bus.req_valid),
        .i_update    (w_update),
        .i_update_id (r_gid),
        .o_any_c     (w_any),
        .o_win_c     (w_win)
    );

    assign w_sel_addr  = w_win ? bus.req_addr[2*ADDR_W-1 -: ADDR_W]
                               : bus.req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_win ? bus.req_wdata[2*BLOCK_W-1 -: BLOCK_W]
                               : bus.req_wdata[BLOCK_W-1:0];

    // State and transaction latch; request fields are frozen at acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_gid   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_gid   <= w_win;
                r_we    <= bus.req_we[w_win];
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt        = w_state;
        w_latch            = 1'b0;
        w_update           = 1'b0;
        bus.req_ready      = '0;
        bus.resp_valid     = '0;
        bus.resp_rdata     = '0;
        bus.req_valid_mem  = 1'b0;
        bus.read_en_mem    = 1'b0;
        bus.write_en_mem   = 1'b0;
        bus.resp_ready_mem = 1'b0;
        case (w_state)
            ARB_IDLE: begin
                if (w_any) begin
                    bus.req_ready[w_win] = 1'b1;
                    w_latch              = 1'b1;
                    w_state_nxt          = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.req_valid_mem = 1'b1;
                bus.write_en_mem  = r_we & bus.req_ready_mem;
                bus.read_en_mem   = ~r_we & bus.req_ready_mem;
                if (bus.req_ready_mem) begin
                    if (r_we) begin
                        w_update    = 1'b1;
                        w_state_nxt = ARB_IDLE;
                    end else begin
                        w_state_nxt = ARB_RESP;
                    end
                end
            end
            ARB_RESP: begin
                bus.resp_ready_mem    = bus.resp_ready[r_gid];
                bus.resp_valid[r_gid] = bus.resp_valid_mem;
                bus.resp_rdata        = bus.rdata_mem;
                if (bus.resp_valid_mem && bus.resp_ready[r_gid]) begin
                    w_update    = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign bus.addr_mem  = rst ? r_addr  : '0;
    assign bus.wdata_mem = rst ? r_wdata : '0;
    assign bus.grant_id  = rst ? r_gid   : 1'b0;
    assign bus.busy      = (w_state != ARB_IDLE);

endmodule
